// File: rtl/dsp_simd_pkg.sv
// Shared types and limits for the SIMD add/sub/accumulate ALU.
package dsp_simd_pkg;

  localparam int unsigned DSP_MAX_WIDTH = 32'd48;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_ACC = 2'd2,
    OP_CLR = 2'd3
  } op_t;

endpackage

// File: rtl/dsp_simd_lane.sv
// One SIMD lane: combinational add/sub/accumulate result plus its accumulator register.
module dsp_simd_lane
  import dsp_simd_pkg::*;
#(
  parameter int unsigned WIDTH = 32'd12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance_i,
  input  op_t              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o,
  output logic             carry_o
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH:0]   sum_s;

  // Lane arithmetic; bit WIDTH of the widened sum/difference is carry or borrow.
  always_comb begin
    sum_s   = {(WIDTH+1){1'b0}};
    y_o     = {WIDTH{1'b0}};
    carry_o = 1'b0;
    acc_d   = acc_q;
    case (op_i)
      OP_ADD: begin
        sum_s   = {1'b0, a_i} + {1'b0, b_i};
        y_o     = sum_s[WIDTH-1:0];
        carry_o = sum_s[WIDTH];
      end
      OP_SUB: begin
        sum_s   = {1'b0, a_i} - {1'b0, b_i};
        y_o     = sum_s[WIDTH-1:0];
        carry_o = sum_s[WIDTH];
      end
      OP_ACC: begin
        sum_s   = {1'b0, acc_q} + {1'b0, a_i};
        y_o     = sum_s[WIDTH-1:0];
        carry_o = sum_s[WIDTH];
        acc_d   = sum_s[WIDTH-1:0];
      end
      OP_CLR: begin
        acc_d = {WIDTH{1'b0}};
      end
      default: begin
        acc_d = acc_q;
      end
    endcase
  end

  // Accumulator commits only when its beat leaves the operand stage.
  always_ff @(posedge clock) begin
    if (!reset) begin
      acc_q <= {WIDTH{1'b0}};
    end else if (advance_i) begin
      acc_q <= acc_d;
    end else begin
      acc_q <= acc_q;
    end
  end

endmodule

// File: rtl/dsp_simd_alu.sv
// Two-stage SIMD ALU (operand register, result register) with a global stall enable
// and per-lane accumulators; lanes are carry-isolated.
module dsp_simd_alu
  import dsp_simd_pkg::*;
#(
  parameter int unsigned WIDTH = 32'd12,
  parameter int unsigned LANES = 32'd4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  op_t                    op,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] y,
  output logic [LANES-1:0]       carry
);

  localparam int unsigned DW = LANES * WIDTH;

  if (WIDTH < 32'd8 || WIDTH > DSP_MAX_WIDTH) begin : g_bad_width
    $error("dsp_simd_alu: WIDTH must be within 8..48");
  end
  if (LANES != 32'd1 && LANES != 32'd2 && LANES != 32'd4) begin : g_bad_lanes
    $error("dsp_simd_alu: LANES must be 1, 2 or 4");
  end
  if (DW > DSP_MAX_WIDTH) begin : g_bad_total
    $error("dsp_simd_alu: LANES*WIDTH exceeds the 48-bit DSP datapath");
  end

  logic             en_s;
  logic             advance_s;
  logic             s1_valid_q, s1_valid_d;
  op_t              s1_op_q, s1_op_d;
  logic [DW-1:0]    s1_a_q, s1_a_d;
  logic [DW-1:0]    s1_b_q, s1_b_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    y_q, y_d;
  logic [LANES-1:0] carry_q, carry_d;
  logic [DW-1:0]    lane_y_s;
  logic [LANES-1:0] lane_c_s;

  assign en_s      = out_ready | ~out_valid_q;
  assign advance_s = en_s & s1_valid_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    dsp_simd_lane #(.WIDTH(WIDTH)) u_lane (
      .clock     (clock),
      .reset     (reset),
      .advance_i (advance_s),
      .op_i      (s1_op_q),
      .a_i       (s1_a_q[g*WIDTH +: WIDTH]),
      .b_i       (s1_b_q[g*WIDTH +: WIDTH]),
      .y_o       (lane_y_s[g*WIDTH +: WIDTH]),
      .carry_o   (lane_c_s[g])
    );
  end

  // Next state for both stages; nothing moves while the output is stalled.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    carry_d     = carry_q;
    if (en_s) begin
      s1_valid_d  = in_valid;
      out_valid_d = s1_valid_q;
      if (in_valid) begin
        s1_op_d = op;
        s1_a_d  = a;
        s1_b_d  = b;
      end else begin
        s1_op_d = s1_op_q;
      end
      if (s1_valid_q) begin
        y_d     = lane_y_s;
        carry_d = lane_c_s;
      end else begin
        y_d = y_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Pipeline registers; the result register with en as clock enable is the DSP P register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_ADD;
      s1_a_q      <= {DW{1'b0}};
      s1_b_q      <= {DW{1'b0}};
      out_valid_q <= 1'b0;
      y_q         <= {DW{1'b0}};
      carry_q     <= {LANES{1'b0}};
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      carry_q     <= carry_d;
    end
  end

  assign in_ready  = en_s;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_dsp_simd_alu.sv
// Scoreboard bench for dsp_simd_alu in three shapes: 12x4 (index 0), 24x2 (1), 48x1 (2).
module tb_dsp_simd_alu;
  import dsp_simd_pkg::*;

  typedef struct {
    logic [47:0] y;
    logic [3:0]  c;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        iv   [3];
  logic        ordy [3];
  logic        irdy [3];
  logic        ov   [3];
  op_t         op_s [3];
  logic [47:0] a_s  [3];
  logic [47:0] b_s  [3];
  logic [47:0] y_s  [3];
  logic [3:0]  c_s  [3];
  logic [3:0]  c12;
  logic [1:0]  c24;
  logic [0:0]  c48;

  exp_t            sb[$];
  longint unsigned acc_m [3][4];
  int              errors = 0;
  int              checks = 0;

  always #5 clock = ~clock;

  dsp_simd_alu #(.WIDTH(12), .LANES(4)) u12 (
    .clock(clock), .reset(reset), .in_valid(iv[0]), .in_ready(irdy[0]), .op(op_s[0]),
    .a(a_s[0]), .b(b_s[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .y(y_s[0]), .carry(c12));
  dsp_simd_alu #(.WIDTH(24), .LANES(2)) u24 (
    .clock(clock), .reset(reset), .in_valid(iv[1]), .in_ready(irdy[1]), .op(op_s[1]),
    .a(a_s[1]), .b(b_s[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .y(y_s[1]), .carry(c24));
  dsp_simd_alu #(.WIDTH(48), .LANES(1)) u48 (
    .clock(clock), .reset(reset), .in_valid(iv[2]), .in_ready(irdy[2]), .op(op_s[2]),
    .a(a_s[2]), .b(b_s[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .y(y_s[2]), .carry(c48));

  assign c_s[0] = c12;
  assign c_s[1] = {2'b00, c24};
  assign c_s[2] = {3'b000, c48};

  // Reference lane arithmetic on 64-bit integers; also advances the accumulator model.
  function automatic void model(input int s, input op_t o, input logic [47:0] av,
                                input logic [47:0] bv, output logic [47:0] ye,
                                output logic [3:0] ce);
    int w;
    int l;
    longint unsigned mask, ai, bi, r;
    w    = (s == 0) ? 12 : (s == 1) ? 24 : 48;
    l    = 48 / w;
    mask = (64'd1 << w) - 64'd1;
    ye   = '0;
    ce   = '0;
    for (int i = 0; i < l; i++) begin
      ai = 64'(av >> (i * w)) & mask;
      bi = 64'(bv >> (i * w)) & mask;
      case (o)
        OP_ADD: begin r = ai + bi; ce[i] = ((r >> w) != 0); end
        OP_SUB: begin r = (ai - bi) & mask; ce[i] = (ai < bi); end
        OP_ACC: begin
          r = acc_m[s][i] + ai; ce[i] = ((r >> w) != 0); acc_m[s][i] = r & mask;
        end
        default: begin r = 0; acc_m[s][i] = 0; end
      endcase
      ye = ye | 48'((r & mask) << (i * w));
    end
  endfunction

  function automatic void clear_model();
    sb.delete();
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 4; i++) acc_m[s][i] = 0;
  endfunction

  // One clock of traffic on DUT s: compare any delivered beat, record any accepted beat.
  task automatic cyc(input int s, input bit v, input op_t o, input logic [47:0] av,
                     input logic [47:0] bv, input bit rd);
    exp_t e;
    logic [47:0] ye;
    logic [3:0]  ce;
    iv[s] = v; op_s[s] = o; a_s[s] = av; b_s[s] = bv; ordy[s] = rd;
    #1;
    if (ov[s] && rd) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_extra dut%0d: got y=%h carry=%b, required no beat", s, y_s[s], c_s[s]);
      end else begin
        e = sb.pop_front();
        if (y_s[s] !== e.y || c_s[s] !== e.c) begin
          errors++;
          $display("FAIL sb_data dut%0d: got y=%h carry=%b, required y=%h carry=%b",
                   s, y_s[s], c_s[s], e.y, e.c);
        end
      end
    end
    if (v && irdy[s]) begin
      model(s, o, av, bv, ye, ce);
      e.y = ye; e.c = ce;
      sb.push_back(e);
    end
    @(negedge clock);
  endtask

  task automatic drain(input int s, input string name);
    for (int k = 0; k < 30 && sb.size() != 0; k++) cyc(s, 1'b0, OP_ADD, '0, '0, 1'b1);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Single beat with fixed expectations; also pins the two-edge latency.
  task automatic direct(input int s, input string name, input op_t o, input logic [47:0] av,
                        input logic [47:0] bv, input logic [47:0] ye, input logic [3:0] ce);
    iv[s] = 1'b1; op_s[s] = o; a_s[s] = av; b_s[s] = bv; ordy[s] = 1'b1;
    @(negedge clock);
    iv[s] = 1'b0;
    #1;
    checks++;
    if (ov[s] !== 1'b0) begin
      errors++;
      $display("FAIL %s_early: got out_valid=%b one edge after accept, required 0", name, ov[s]);
    end
    @(negedge clock);
    #1;
    checks++;
    if (ov[s] !== 1'b1 || y_s[s] !== ye || c_s[s] !== ce) begin
      errors++;
      $display("FAIL %s_result: got valid=%b y=%h carry=%b, required valid=1 y=%h carry=%b",
               name, ov[s], y_s[s], c_s[s], ye, ce);
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int s = 0; s < 3; s++) begin
      iv[s] = 1'b1; op_s[s] = OP_ACC; a_s[s] = 48'h123456789ABC; b_s[s] = 48'h1; ordy[s] = 1'b1;
    end
    repeat (3) @(negedge clock);
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (ov[s] !== 1'b0 || y_s[s] !== 48'h0 || c_s[s] !== 4'h0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got valid=%b y=%h carry=%b, required 0/0/0",
                 s, ov[s], y_s[s], c_s[s]);
      end
    end
    reset = 1'b1;
    for (int s = 0; s < 3; s++) iv[s] = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (irdy[s] !== 1'b1) begin
        errors++;
        $display("FAIL reset_ready dut%0d: got in_ready=%b, required 1", s, irdy[s]);
      end
    end
    @(negedge clock);
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (ov[s] !== 1'b0) begin
        errors++;
        $display("FAIL reset_ignored dut%0d: got out_valid=%b, required 0", s, ov[s]);
      end
    end
    clear_model();
  endtask

  task automatic test_add12();
    direct(0, "add12", OP_ADD, {12'hFEC, 12'd255, 12'd23, 12'hFFF},
           {12'hFF9, 12'd7, 12'd7, 12'd16}, {12'hFE5, 12'd262, 12'd30, 12'd15}, 4'b1001);
  endtask

  task automatic test_sub24();
    direct(1, "sub24", OP_SUB, {24'd0, 24'd5}, {24'd1, 24'd3}, {24'hFFFFFF, 24'd2}, 4'b0010);
  endtask

  task automatic test_add48();
    direct(2, "add48", OP_ADD, 48'hFFFFFFFFFFFF, 48'd1, 48'd0, 4'b0001);
  endtask

  task automatic test_acc_chain();
    logic [47:0] ten;
    ten = {12'd10, 12'd10, 12'd10, 12'd10};
    cyc(0, 1'b1, OP_CLR, ten, '0, 1'b1);
    repeat (3) cyc(0, 1'b1, OP_ACC, ten, '0, 1'b1);
    repeat (2) cyc(0, 1'b0, OP_ADD, '0, '0, 1'b1);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL acc_chain_bubble: got %0d beats late, required 0", sb.size());
    end
    drain(0, "acc_chain");
  endtask

  task automatic test_stall();
    logic [47:0] y_hold;
    logic [3:0]  c_hold;
    cyc(0, 1'b1, OP_ACC, {12'd4, 12'd3, 12'd2, 12'd1}, '0, 1'b1);
    cyc(0, 1'b1, OP_ACC, {12'd8, 12'd7, 12'd6, 12'hFFF}, '0, 1'b1);
    y_hold = y_s[0];
    c_hold = c_s[0];
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1'b1, OP_ACC, {12'd99, 12'd99, 12'd99, 12'd99}, '0, 1'b0);
      checks++;
      if (ov[0] !== 1'b1 || y_s[0] !== y_hold || c_s[0] !== c_hold || irdy[0] !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: got valid=%b y=%h carry=%b in_ready=%b, required 1 %h %b 0",
                 ov[0], y_s[0], c_s[0], irdy[0], y_hold, c_hold);
      end
    end
    drain(0, "stall");
    cyc(0, 1'b1, OP_ACC, {12'd1, 12'd1, 12'd1, 12'd1}, '0, 1'b1);
    drain(0, "stall_after");
  endtask

  task automatic test_reset_mid();
    cyc(0, 1'b1, OP_ACC, {12'd7, 12'd7, 12'd7, 12'd7}, '0, 1'b1);
    cyc(0, 1'b1, OP_ACC, {12'd7, 12'd7, 12'd7, 12'd7}, '0, 1'b1);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (ov[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_valid: got out_valid=%b, required 0", ov[0]);
    end
    reset = 1'b1;
    iv[0] = 1'b0;
    clear_model();
    #1;
    checks++;
    if (irdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready: got in_ready=%b, required 1", irdy[0]);
    end
    @(negedge clock);
    cyc(0, 1'b1, OP_ACC, {12'd4, 12'd4, 12'd4, 12'd4}, '0, 1'b1);
    drain(0, "reset_mid");
  endtask

  task automatic test_random(input int s, input int n);
    op_t o;
    for (int k = 0; k < n; k++) begin
      o = op_t'($urandom_range(0, 3));
      cyc(s, 1'($urandom_range(0, 3) != 0), o, {$urandom(), $urandom()} >> 16,
          {$urandom(), $urandom()} >> 16, 1'($urandom_range(0, 3) != 0));
    end
    drain(s, "random");
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      iv[s] = 1'b0; ordy[s] = 1'b1; op_s[s] = OP_ADD; a_s[s] = '0; b_s[s] = '0;
    end
    reset = 1'b0;
    clear_model();
    @(negedge clock);
    test_reset();
    test_add12();
    test_sub24();
    test_add48();
    test_acc_chain();
    test_stall();
    test_reset_mid();
    test_random(0, 80);
    test_random(1, 40);
    test_random(2, 40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dsp_simd_alu.md
DSP_SIMD_ALU -- requirements
Module: dsp_simd_alu

Interface
REQ-001 Parameter WIDTH, default 12: lane width in bits, legal range 8..48.
REQ-002 Parameter LANES, default 4: independent SIMD lanes, legal values 1, 2, 4; LANES*WIDTH SHALL be <= 48, enforced by elaboration-time assertion.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 op  input  2  operation code (op_t).
REQ-008 a  input  LANES*WIDTH  packed lane operands A, lane i at bits [i*WIDTH +: WIDTH].
REQ-009 b  input  LANES*WIDTH  packed lane operands B, same packing.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 y  output  LANES*WIDTH  packed lane results.
REQ-013 carry  output  LANES  per-lane carry-out (ADD/ACC) or borrow (SUB).

Function
REQ-014 Op codes SHALL be ADD=0 (y=a+b), SUB=1 (y=a-b), ACC=2 (acc+=a, y=new acc), CLR=3 (acc=0, y=0).
REQ-015 Arithmetic SHALL wrap modulo 2^WIDTH per lane; no carry propagates between lanes.
REQ-016 carry[i] SHALL be bit WIDTH of the (WIDTH+1)-bit unsigned lane sum for ADD/ACC, 1 when a_i < b_i unsigned for SUB, 0 for CLR.
REQ-017 Pipeline SHALL be two register stages (operand, result); a beat accepted at edge N SHALL appear on y with out_valid at edge N+2 when out_ready stays high.
REQ-018 Global enable en = out_ready OR NOT out_valid; in_ready SHALL equal en; both stages advance only when en is high.
REQ-019 A beat SHALL be accepted only when in_valid AND in_ready; bubbles SHALL propagate as out_valid low.
REQ-020 While out_valid high and out_ready low, y, carry and out_valid SHALL hold stable and no beat SHALL be lost or duplicated.
REQ-021 Per-lane accumulator acc_i (WIDTH bits) SHALL update only when an ACC or CLR beat advances out of stage 1.
REQ-022 Back-to-back ACC beats SHALL chain with no bubble: each sees acc updated by its predecessor.
REQ-023 ADD and SUB beats SHALL NOT modify acc.
REQ-024 Stalled ACC beats SHALL update acc exactly once, when they advance.

Reset
REQ-025 While reset low at a rising edge: out_valid=0, y=0, carry=0, all acc=0, both stage-valid flags=0.
REQ-026 Reset mid-operation SHALL discard all in-flight beats; in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-027 in_valid during reset SHALL be ignored.

Structure
REQ-028 Package dsp_simd_pkg SHALL hold op_t enum and the max DSP width constant (48).
REQ-029 Sub-module dsp_simd_lane SHALL implement one lane (add/sub/acc, carry, acc register), instantiated LANES times via generate.
REQ-030 Result stage SHALL be coded to map onto one DSP48E2 in SIMD mode (ONE48/TWO24/FOUR12) when WIDTH matches.

Verification
REQ-031 WIDTH=12, LANES=4, ADD a={-1,23,255,-20}, b={16,7,7,-7} -> y={15,30,262,-27} mod 2^12, carry={1,0,0,1}, two cycles after accept.
REQ-032 WIDTH=24, LANES=2, SUB a={5,0}, b={3,1} -> y={2,0xFFFFFF}, carry={0,1}.
REQ-033 CLR then ACC a=10 three consecutive beats, each lane -> y sequence 0,10,20,30, no bubbles.
REQ-034 out_ready low 3 cycles with two beats in flight -> y stable, in_ready=0, both beats delivered in order after release, acc updated once each.
REQ-035 Reset asserted with two ACC beats in flight -> out_valid=0 next cycle; next ACC a=4 yields y=4.
REQ-036 WIDTH=48, LANES=1, ADD 0xFFFFFFFFFFFF+1 -> y=0, carry=1.
